data_mem_arbiter: RTL
=====================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port DataMemory between the pipeline MEM stage and a debug/preload port.
//  Sequences every access as a multi-cycle transaction with a programmable wait-state count.
//  Raises mem_stall to freeze PC/nPC, IF/ID and the ID/EX, EX/MEM and MEM/WB registers until
//  the pipeline's access completes. Sits between the EX/MEM register outputs and DataMemory.
// PARAMETERS
//  WAIT_CYC      1   extra DataMemory cycles per access (0..15); an access occupies WAIT_CYC+1 ACC cycles
//  DBG_MAX_WAIT  4   denied-cycle count at which a pending debug request beats the pipeline (1..15)
// PORTS
//  Clk           in   1   rising-edge clock
//  R             in   1   asynchronous active-low reset
//  mem_req       in   1   pipeline access request (MEM_DataMem_enable)
//  mem_rw        in   1   pipeline direction: 0=read, 1=write
//  mem_addr      in   32  pipeline byte address (MEM_ALU_Out)
//  mem_wdata     in   32  pipeline store data (MEM_DataIn)
//  mem_size      in   2   00=byte, 01=half, 10=word; 11 is treated as word
//  mem_se        in   1   sign-extend load data
//  mem_rdata     out  32  pipeline load data; valid in the completion cycle only
//  mem_stall     out  1   pipeline freeze request
//  mem_err       out  1   one-cycle pulse: misaligned pipeline access was dropped
//  dbg_req       in   1   debug request; held until dbg_done
//  dbg_rw        in   1   debug direction: 0=read, 1=write
//  dbg_addr      in   32  debug byte address
//  dbg_wdata     in   32  debug store data
//  dbg_size      in   2   debug size; same encoding as mem_size; loads are never sign-extended
//  dbg_gnt       out  1   high throughout the debug transaction
//  dbg_done      out  1   one-cycle completion pulse
//  dbg_err       out  1   pulse with dbg_done when the debug access was misaligned
//  dbg_rdata     out  32  registered debug read data; held until the next debug completion
//  dm_enable     out  1   DataMemory enable
//  dm_rw         out  1   DataMemory Read_Write
//  dm_addr       out  32  DataMemory address
//  dm_wdata      out  32  DataMemory data in
//  dm_size       out  2   DataMemory size
//  dm_se         out  1   DataMemory sign-extend
//  dm_rdata      in   32  DataMemory load data (combinational)
//  state         out  2   00=IDLE, 01=MEM_ACC, 10=DBG_ACC
// BEHAVIOUR
//  Reset (R=0, asynchronous)
//  - State goes to IDLE; cnt and dbg_age are cleared.
//  - All outputs are 0 while R=0, including mem_stall and dbg_rdata.
//  State machine (registered; cnt is a 4-bit down-counter)
//  - IDLE:
//    - If dbg_req && (dbg_age==DBG_MAX_WAIT || !mem_req): go to DBG_ACC, cnt=WAIT_CYC, dbg_age=0.
//    - Else if mem_req: go to MEM_ACC, cnt=WAIT_CYC.
//  - MEM_ACC / DBG_ACC:
//    - While cnt!=0, decrement cnt.
//    - cnt==0 is the completion cycle; at the next edge go to IDLE (always; no direct chaining).
//    - mem_req falling during MEM_ACC aborts: dm_enable=0 in that cycle, IDLE next edge, no mem_err.
//    - dbg_req falling during DBG_ACC does not abort; the transaction completes and dbg_done pulses.
//  Aging
//  - dbg_age increments, saturating at DBG_MAX_WAIT, on every edge where dbg_req=1 and state!=DBG_ACC
//    and no debug grant is taken.
//  Datapath outputs
//  - dm_* are driven from the granted requester only in the ACC states.
//  - dm_enable=1 for every ACC cycle of an aligned access; 0 in IDLE, for misaligned accesses, and in abort cycles.
//  - Misaligned = (half && addr[0]) || (word && addr[1:0]!=0). Such an access still spends its ACC cycles but
//    never asserts dm_enable; on completion mem_rdata=0, and mem_err (or dbg_err) pulses.
//  Pipeline side
//  - mem_stall = mem_req && !(state==MEM_ACC && cnt==0).
//  - Completion: mem_rdata=dm_rdata combinationally in the MEM_ACC cnt==0 cycle (0 otherwise), so MEM/WB
//    captures the load at that edge.
//  - Latency: mem_stall is high for WAIT_CYC+1 cycles from the IDLE cycle, longer if a debug access is granted first.
//  Debug side
//  - dbg_gnt = (state==DBG_ACC).
//  - dbg_done pulses in the DBG_ACC cnt==0 cycle; dbg_rdata is registered from dm_rdata at that edge on reads.
//  - dm_se=0 for all debug accesses.
// TESTING
//  T1: R=0 asserted mid-DBG_ACC -> state=00, dm_enable=0, dbg_gnt=0, mem_stall=0 immediately; R=1 -> IDLE, no dbg_done.
//  T2: WAIT_CYC=1; Mem[44..47]=DEADBEEF; pipeline word load addr 44 -> mem_stall=1,1,0; mem_rdata=0xDEADBEEF in cycle 3.
//  T3: mem_req and dbg_req both rise in IDLE with dbg_age=0 -> MEM_ACC first, then DBG_ACC; dbg_done after the pipeline access.
//  T4: mem_req held, dbg_req held, DBG_MAX_WAIT=4 -> dbg granted in the IDLE cycle where dbg_age==4; mem_stall stays high throughout.
//  T5: pipeline word store 0x12345678 to addr 46 -> dm_enable never 1, mem_err=1 for one cycle, Mem[44..47] unchanged.
//  T6: debug byte write 0xA5 to addr 3, then debug byte read addr 3 -> dbg_rdata=0x000000A5, dbg_err=0.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the pipeline MEM stage, the debug/preload port, the
// arbiter and the single-port DataMemory.
// The slave modport is the arbiter's view. The master modport is the
// surrounding system: the pipeline, the debug port and DataMemory together.
interface data_mem_arbiter_if;

  // Pipeline MEM stage
  logic        mem_req;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_se;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        mem_err;

  // Debug / preload port
  logic        dbg_req;
  logic        dbg_rw;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [1:0]  dbg_size;
  logic        dbg_gnt;
  logic        dbg_done;
  logic        dbg_err;
  logic [31:0] dbg_rdata;

  // DataMemory
  logic        dm_enable;
  logic        dm_rw;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [1:0]  dm_size;
  logic        dm_se;
  logic [31:0] dm_rdata;

  modport slave (
    input  mem_req, mem_rw, mem_addr, mem_wdata, mem_size, mem_se,
    output mem_rdata, mem_stall, mem_err,
    input  dbg_req, dbg_rw, dbg_addr, dbg_wdata, dbg_size,
    output dbg_gnt, dbg_done, dbg_err, dbg_rdata,
    output dm_enable, dm_rw, dm_addr, dm_wdata, dm_size, dm_se,
    input  dm_rdata
  );

  modport master (
    output mem_req, mem_rw, mem_addr, mem_wdata, mem_size, mem_se,
    input  mem_rdata, mem_stall, mem_err,
    output dbg_req, dbg_rw, dbg_addr, dbg_wdata, dbg_size,
    input  dbg_gnt, dbg_done, dbg_err, dbg_rdata,
    input  dm_enable, dm_rw, dm_addr, dm_wdata, dm_size, dm_se,
    output dm_rdata
  );

endinterface

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port DataMemory between the pipeline MEM stage and
// the debug/preload port. Every access takes WAIT_CYC+1 cycles.
// The pipeline is frozen with mem_stall until its own access completes.
module data_mem_arbiter #(
  parameter int unsigned WAIT_CYC     = 1,
  parameter int unsigned DBG_MAX_WAIT = 4
) (
  input  logic              Clk,
  input  logic              R,
  data_mem_arbiter_if.slave bus,
  output logic [1:0]        state
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYC);
  localparam logic [CNT_W-1:0] AGE_MAX  = CNT_W'(DBG_MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MEM_ACC = 2'b01,
    DBG_ACC = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] age_q, age_d;
  logic [31:0]      dbg_rdata_q, dbg_rdata_d;

  logic [1:0] mem_sz, dbg_sz;
  logic       mem_mis, dbg_mis;
  logic       last;

  // Size 11 behaves as a word everywhere, including at the memory
  assign mem_sz = (bus.mem_size == 2'b11) ? 2'b10 : bus.mem_size;
  assign dbg_sz = (bus.dbg_size == 2'b11) ? 2'b10 : bus.dbg_size;

  // Misalignment detection on the normalised size
  assign mem_mis = ((mem_sz == 2'b01) && bus.mem_addr[0]) ||
                   ((mem_sz == 2'b10) && (bus.mem_addr[1:0] != 2'b00));
  assign dbg_mis = ((dbg_sz == 2'b01) && bus.dbg_addr[0]) ||
                   ((dbg_sz == 2'b10) && (bus.dbg_addr[1:0] != 2'b00));

  assign last  = (cnt_q == '0);
  assign state = state_q;
  assign bus.dbg_rdata = dbg_rdata_q;

  // State, wait counter, debug age and debug read-data registers
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      age_q       <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      age_q       <= age_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Next-state, arbitration, aging and datapath steering
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    age_d         = age_q;
    dbg_rdata_d   = dbg_rdata_q;
    bus.dm_enable = 1'b0;
    bus.dm_rw     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.dm_size   = 2'b00;
    bus.dm_se     = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_err   = 1'b0;
    bus.dbg_gnt   = 1'b0;
    bus.dbg_done  = 1'b0;
    bus.dbg_err   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.dbg_req && ((age_q == AGE_MAX) || !bus.mem_req)) begin
          state_d = DBG_ACC;
          cnt_d   = CNT_INIT;
          age_d   = '0;
        end else if (bus.mem_req) begin
          state_d = MEM_ACC;
          cnt_d   = CNT_INIT;
        end
      end

      MEM_ACC: begin
        bus.dm_rw     = bus.mem_rw;
        bus.dm_addr   = bus.mem_addr;
        bus.dm_wdata  = bus.mem_wdata;
        bus.dm_size   = mem_sz;
        bus.dm_se     = bus.mem_se;
        if (!bus.mem_req) begin
          // Pipeline withdrew the request: abort without touching memory
          state_d = IDLE;
        end else begin
          bus.dm_enable = !mem_mis;
          if (last) begin
            state_d       = IDLE;
            bus.mem_rdata = mem_mis ? 32'h0 : bus.dm_rdata;
            bus.mem_err   = mem_mis;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      DBG_ACC: begin
        bus.dbg_gnt   = 1'b1;
        bus.dm_enable = !dbg_mis;
        bus.dm_rw     = bus.dbg_rw;
        bus.dm_addr   = bus.dbg_addr;
        bus.dm_wdata  = bus.dbg_wdata;
        bus.dm_size   = dbg_sz;
        if (last) begin
          state_d      = IDLE;
          bus.dbg_done = 1'b1;
          bus.dbg_err  = dbg_mis;
          if (!bus.dbg_rw) begin
            dbg_rdata_d = dbg_mis ? 32'h0 : bus.dm_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // A waiting debug request ages until it is granted
    if (bus.dbg_req && (state_q != DBG_ACC) && (state_d != DBG_ACC) &&
        (age_q != AGE_MAX)) begin
      age_d = age_q + CNT_W'(1);
    end
  end

  // Freeze the pipeline until its access reaches the completion cycle
  always_comb begin
    bus.mem_stall = R && bus.mem_req && !((state_q == MEM_ACC) && last);
  end

endmodule
